// File: rtl/lamp_bank_pkg.sv
// Shared definitions for the lamp bank controller: mode encodings and a popcount helper.
package lamp_bank_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE    = 2'b00,
        MODE_MOMENTARY = 2'b01,
        MODE_RADIO     = 2'b10,
        MODE_HOLD      = 2'b11
    } lamp_mode_e;

    localparam int MAX_LAMPS = 32;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/lamp_bank_ctrl_debounce.sv
// Per-button conditioning: 2-flop synchroniser, consecutive-cycle debounce filter, registered rise pulse.
// Rise pulse appears DEBOUNCE_CYCLES+2 edges after the raw input is first sampled; no backpressure.
module button_debounce
    import lamp_bank_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_button,
    output logic o_db,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_db_d;
    logic r_rise;
    logic w_db;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign w_db = r_sync2;
        end else begin : g_filter
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] r_cnt;
            logic          r_db;

            // The level flips on the edge that completes the Nth consecutive differing sample.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_db  <= 1'b0;
                end else if (r_sync2 == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == LAST) begin
                    r_cnt <= '0;
                    r_db  <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_db = r_db;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_db_d <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_db_d <= w_db;
            r_rise <= w_db & ~r_db_d;
        end
    end

    assign o_db   = w_db;
    assign o_rise = r_rise;

endmodule

// File: rtl/lamp_bank_ctrl.sv
// N-channel lamp controller (toggle/momentary/radio/hold) with saturating press counter.
// Press-to-lamp latency DEBOUNCE_CYCLES+3 edges; no backpressure. Optional idle auto-off: LAMP_AUTO_OFF_EN.
module lamp_bank_ctrl
    import lamp_bank_pkg::*;
#(
    parameter int N_LAMPS         = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_LAMPS-1:0] button,
    input  logic [1:0]         mode,
    output logic [N_LAMPS-1:0] lamp,
    output logic [N_LAMPS-1:0] press_evt,
    output logic [CNT_W-1:0]   press_count,
    output logic [N_LAMPS-1:0] auto_off_evt
);

    localparam int SUM_W = CNT_W + 6;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [N_LAMPS-1:0] ONE_N = N_LAMPS'(1);

    logic [N_LAMPS-1:0] w_db;
    logic [N_LAMPS-1:0] w_press;
    logic [N_LAMPS-1:0] w_radio_sel;
    logic [N_LAMPS-1:0] w_fire;
    logic [N_LAMPS-1:0] w_lamp_nxt;
    logic [5:0]         w_pop;
    logic [SUM_W-1:0]   w_sum;
    logic [CNT_W-1:0]   w_cnt_nxt;
    lamp_mode_e         w_mode;

    logic [N_LAMPS-1:0] r_lamp;
    logic [N_LAMPS-1:0] r_press_evt;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_LAMPS-1:0] r_auto;

    genvar gi;
    generate
        for (gi = 0; gi < N_LAMPS; gi++) begin : g_chan
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk      (clk),
                .reset    (reset),
                .i_button (button[gi]),
                .o_db     (w_db[gi]),
                .o_rise   (w_press[gi])
            );
        end
    endgenerate

    assign w_mode      = lamp_mode_e'(mode);
    // Two's-complement trick isolates the lowest set bit, i.e. the winning radio channel.
    assign w_radio_sel = w_press & (~w_press + ONE_N);

`ifdef LAMP_AUTO_OFF_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

    logic [IW-1:0]      r_idle [N_LAMPS];
    logic [N_LAMPS-1:0] w_timeout;

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_LAMPS; i++) begin
            if (reset || w_press[i] || !r_lamp[i]) begin
                r_idle[i] <= '0;
            end else if (r_idle[i] != IDLE_LAST) begin
                r_idle[i] <= r_idle[i] + 1'b1;
            end
        end
    end

    always_comb begin
        w_timeout = '0;
        for (int i = 0; i < N_LAMPS; i++) begin
            w_timeout[i] = r_lamp[i] && (r_idle[i] == IDLE_LAST);
        end
    end

    // Radio presses rewrite the whole bank, so any press there overrides every pending timeout.
    always_comb begin
        w_fire = '0;
        case (w_mode)
            MODE_TOGGLE: w_fire = w_timeout & ~w_press;
            MODE_RADIO:  w_fire = (|w_press) ? '0 : w_timeout;
            default:     w_fire = '0;
        endcase
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign w_fire           = '0;
`endif

    always_comb begin
        w_lamp_nxt = r_lamp;
        case (w_mode)
            MODE_TOGGLE:    w_lamp_nxt = r_lamp ^ w_press;
            MODE_MOMENTARY: w_lamp_nxt = w_db;
            MODE_RADIO: begin
                if (|w_press) begin
                    w_lamp_nxt = (r_lamp == w_radio_sel) ? '0 : w_radio_sel;
                end
            end
            default:        w_lamp_nxt = r_lamp;
        endcase
        w_lamp_nxt = w_lamp_nxt & ~w_fire;
    end

    assign w_pop     = popcount32(32'(w_press));
    assign w_sum     = SUM_W'(r_cnt) + SUM_W'(w_pop);
    assign w_cnt_nxt = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lamp      <= '0;
            r_press_evt <= '0;
            r_cnt       <= '0;
            r_auto      <= '0;
        end else begin
            r_lamp      <= w_lamp_nxt;
            r_press_evt <= w_press;
            r_cnt       <= w_cnt_nxt;
            r_auto      <= w_fire;
        end
    end

    assign lamp         = r_lamp;
    assign press_evt    = r_press_evt;
    assign press_count  = r_cnt;
    assign auto_off_evt = r_auto;

endmodule
